// File: rtl/matrix_multiply_seq.sv
// Sequential signed matrix multiplier: C = A*B, or C = C + A*B in accumulate mode.
// One reduction index per cycle through registered products; result clipped or wrapped.
module matrix_multiply_seq #(
   parameter int ROWS     = 2,
   parameter int INNER    = 2,
   parameter int COLS     = 2,
   parameter int DATA_W   = 16,
   parameter int OUT_W    = 32,
   parameter int SATURATE = 1
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       start,
   input  logic                                       acc_mode,
   input  logic [DATA_W*(ROWS*INNER+INNER*COLS)-1:0] matrix_in,
   output logic                                       busy,
   output logic                                       done,
   output logic [OUT_W*ROWS*COLS-1:0]                 matrix_out
);
   localparam int NA    = ROWS * INNER;
   localparam int NB    = INNER * COLS;
   localparam int NC    = ROWS * COLS;
   localparam int PW    = 2 * DATA_W;
   localparam int BW    = (OUT_W > PW) ? OUT_W : PW;
   localparam int ACC_W = BW + $clog2(INNER) + 1;
   localparam int KW    = (INNER > 1) ? $clog2(INNER) : 1;

   localparam logic signed [ACC_W-1:0] SMAX =
      {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SMIN =
      {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DRAIN, S_DONE} state_t;

   state_t                   state_q;
   logic [KW-1:0]            k_q;
   logic                     busy_q;
   logic                     done_q;
   logic [OUT_W*NC-1:0]      out_q;
   logic signed [DATA_W-1:0] a_q    [NA];
   logic signed [DATA_W-1:0] b_q    [NB];
   logic signed [PW-1:0]     prod_q [NC];
   logic signed [ACC_W-1:0]  acc_q  [NC];

   logic signed [DATA_W-1:0] a_sel_d [ROWS];
   logic signed [DATA_W-1:0] b_sel_d [COLS];
   logic signed [PW-1:0]     prod_d  [NC];
   logic [OUT_W-1:0]         res_d   [NC];
   logic [OUT_W-1:0]         cur_d   [NC];
   logic                     accept_d;

   assign accept_d = start && (state_q == S_IDLE || state_q == S_DONE);

   // Operand muxes pick column/row k so only ROWS*COLS multipliers exist.
   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         a_sel_d[r] = '0;
         for (int kk = 0; kk < INNER; kk++)
            if (int'(k_q) == kk) a_sel_d[r] = a_q[r*INNER+kk];
      end
      for (int c = 0; c < COLS; c++) begin
         b_sel_d[c] = '0;
         for (int kk = 0; kk < INNER; kk++)
            if (int'(k_q) == kk) b_sel_d[c] = b_q[kk*COLS+c];
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            prod_d[r*COLS+c] = PW'(a_sel_d[r]) * PW'(b_sel_d[c]);
   end

   // A start in DONE must accumulate onto the result being written, not the stale one.
   always_comb begin
      for (int i = 0; i < NC; i++) begin
         res_d[i] = acc_q[i][OUT_W-1:0];
         if (SATURATE != 0 && acc_q[i] > SMAX)
            res_d[i] = SMAX[OUT_W-1:0];
         else if (SATURATE != 0 && acc_q[i] < SMIN)
            res_d[i] = SMIN[OUT_W-1:0];
         cur_d[i] = (state_q == S_DONE) ? res_d[i]
                                        : out_q[i*OUT_W +: OUT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
         for (int i = 0; i < NA; i++) a_q[i] <= '0;
         for (int i = 0; i < NB; i++) b_q[i] <= '0;
         for (int i = 0; i < NC; i++) begin
            prod_q[i] <= '0;
            acc_q[i]  <= '0;
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_MUL: begin
               for (int i = 0; i < NC; i++) begin
                  prod_q[i] <= prod_d[i];
                  if (k_q != '0)
                     acc_q[i] <= acc_q[i] + ACC_W'(prod_q[i]);
               end
               if (int'(k_q) == INNER - 1) state_q <= S_DRAIN;
               else k_q <= k_q + KW'(1);
            end
            S_DRAIN: begin
               for (int i = 0; i < NC; i++)
                  acc_q[i] <= acc_q[i] + ACC_W'(prod_q[i]);
               busy_q  <= 1'b0;
               state_q <= S_DONE;
            end
            S_DONE: begin
               for (int i = 0; i < NC; i++)
                  out_q[i*OUT_W +: OUT_W] <= res_d[i];
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: ;
         endcase
         if (accept_d) begin
            for (int i = 0; i < NA; i++)
               a_q[i] <= matrix_in[i*DATA_W +: DATA_W];
            for (int j = 0; j < NB; j++)
               b_q[j] <= matrix_in[(NA+j)*DATA_W +: DATA_W];
            for (int i = 0; i < NC; i++)
               acc_q[i] <= acc_mode ? ACC_W'(signed'(cur_d[i])) : '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
         end
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign matrix_out = out_q;

endmodule

// File: tb/tb_matrix_multiply_seq.sv
// Bench for matrix_multiply_seq: fixed-vector table, handshake corner cases
// and randomised parameter sweeps checked through result scoreboards.
module tb_matrix_multiply_seq;
   typedef logic [1023:0] wide_t;
   typedef struct {
      wide_t e0;
      wide_t e1;
      wide_t e2;
      int    c0;
   } sb_t;
   typedef struct {
      logic [127:0] m;
      logic [127:0] e0;
      logic [63:0]  e1;
      logic [63:0]  e2;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         start0 = 1'b0, acc0 = 1'b0;
   logic [127:0] m0 = '0;
   logic         busy0, done0, busy1, done1, busy2, done2;
   logic [127:0] out0;
   logic [63:0]  out1, out2;
   logic         start3 = 1'b0, acc3 = 1'b0;
   logic [111:0] m3 = '0;
   logic         busy3, done3;
   logic [383:0] out3;
   logic         start4 = 1'b0, acc4 = 1'b0;
   logic [255:0] m4 = '0;
   logic         busy4, done4;
   logic [31:0]  out4;

   int  tests = 0, failed = 0, cyc = 0;
   sb_t q0[$], q3[$], q4[$];
   vec_t tbl[5];

   matrix_multiply_seq #(.ROWS(2), .INNER(2), .COLS(2), .DATA_W(16),
      .OUT_W(32), .SATURATE(1)) u0 (.clk(clk), .rst(rst), .start(start0),
      .acc_mode(acc0), .matrix_in(m0), .busy(busy0), .done(done0),
      .matrix_out(out0));
   matrix_multiply_seq #(.ROWS(2), .INNER(2), .COLS(2), .DATA_W(16),
      .OUT_W(16), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .start(start0),
      .acc_mode(acc0), .matrix_in(m0), .busy(busy1), .done(done1),
      .matrix_out(out1));
   matrix_multiply_seq #(.ROWS(2), .INNER(2), .COLS(2), .DATA_W(16),
      .OUT_W(16), .SATURATE(0)) u2 (.clk(clk), .rst(rst), .start(start0),
      .acc_mode(acc0), .matrix_in(m0), .busy(busy2), .done(done2),
      .matrix_out(out2));
   matrix_multiply_seq #(.ROWS(3), .INNER(1), .COLS(4), .DATA_W(16),
      .OUT_W(32), .SATURATE(1)) u3 (.clk(clk), .rst(rst), .start(start3),
      .acc_mode(acc3), .matrix_in(m3), .busy(busy3), .done(done3),
      .matrix_out(out3));
   matrix_multiply_seq #(.ROWS(1), .INNER(8), .COLS(1), .DATA_W(16),
      .OUT_W(32), .SATURATE(1)) u4 (.clk(clk), .rst(rst), .start(start4),
      .acc_mode(acc4), .matrix_in(m4), .busy(busy4), .done(done4),
      .matrix_out(out4));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input wide_t act, input wide_t exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] pk(input int a0, a1, a2, a3,
                                       input int b0, b1, b2, b3);
      return {16'(b3), 16'(b2), 16'(b1), 16'(b0),
              16'(a3), 16'(a2), 16'(a1), 16'(a0)};
   endfunction

   function automatic logic [127:0] o32(input int c0, c1, c2, c3);
      return {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
   endfunction

   function automatic logic [63:0] o16(input int c0, c1, c2, c3);
      return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
   endfunction

   function automatic wide_t ref_mm(input wide_t m, input wide_t prev,
                                    input int R, K, C, W,
                                    input bit sat, input bit acc);
      wide_t o = '0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) begin
            longint s, v, lim;
            s = 0;
            if (acc) begin
               v = 0;
               for (int b = 0; b < W; b++) v[b] = prev[(r*C+c)*W+b];
               v = (v <<< (64 - W)) >>> (64 - W);
               s = v;
            end
            for (int k = 0; k < K; k++)
               s += longint'($signed(m[(r*K+k)*16 +: 16])) *
                    longint'($signed(m[(R*K+k*C+c)*16 +: 16]));
            if (sat) begin
               lim = longint'(1) <<< (W - 1);
               if (s > lim - 1) s = lim - 1;
               else if (s < -lim) s = -lim;
            end
            for (int b = 0; b < W; b++) o[(r*C+c)*W+b] = s[b];
         end
      return o;
   endfunction

   always @(negedge clk) begin : mon0
      sb_t s;
      if (done0) begin
         if (q0.size() == 0) chk("u0 spurious done", wide_t'(done0), '0);
         else begin
            s = q0.pop_front();
            chk("u0 result", out0, s.e0);
            chk("u1 sat16 result", out1, s.e1);
            chk("u2 wrap16 result", out2, s.e2);
            chk("u0 latency", cyc - s.c0, 4);
            chk("u1/u2 done", {done1, done2}, 2'b11);
         end
      end
   end

   always @(negedge clk) begin : mon3
      sb_t s;
      if (done3) begin
         if (q3.size() == 0) chk("u3 spurious done", wide_t'(done3), '0);
         else begin
            s = q3.pop_front();
            chk("u3 result", out3, s.e0);
            chk("u3 latency", cyc - s.c0, 3);
         end
      end
   end

   always @(negedge clk) begin : mon4
      sb_t s;
      if (done4) begin
         if (q4.size() == 0) chk("u4 spurious done", wide_t'(done4), '0);
         else begin
            s = q4.pop_front();
            chk("u4 result", out4, s.e0);
            chk("u4 latency", cyc - s.c0, 10);
         end
      end
   end

   task automatic start_u0(input logic [127:0] m, input bit acc,
                           input wide_t e0, e1, e2);
      start0 = 1'b1;
      m0     = m;
      acc0   = acc;
      q0.push_back('{e0, e1, e2, cyc + 1});
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic wait_u0();
      for (int i = 0; i < 40 && q0.size() != 0; i++) @(negedge clk);
      if (q0.size() != 0) begin
         chk("u0 done timeout", q0.size(), 0);
         q0.delete();
      end
   endtask

   initial begin
      int n;
      wide_t prev3, prev4, e;
      bit a;

      tbl[0] = '{pk(1, 2, 3, 4, 5, 6, 7, 8), o32(19, 22, 43, 50),
                 o16(19, 22, 43, 50), o16(19, 22, 43, 50)};
      tbl[1] = '{pk(-1, 2, 3, -4, 5, -6, -7, 8), o32(-19, 22, 43, -50),
                 o16(-19, 22, 43, -50), o16(-19, 22, 43, -50)};
      tbl[2] = '{pk(32767, 32767, 32767, 32767, 32767, -32768, 32767, -32768),
                 o32(2147352578, -2147418112, 2147352578, -2147418112),
                 o16(32767, -32768, 32767, -32768), o16(2, 0, 2, 0)};
      tbl[3] = '{pk(100, -200, 300, 400, 1, 0, 0, 1),
                 o32(100, -200, 300, 400), o16(100, -200, 300, 400),
                 o16(100, -200, 300, 400)};
      tbl[4] = '{pk(1000, 1000, -1000, 0, 40, 0, 0, -40),
                 o32(40000, -40000, -40000, 0), o16(32767, -32768, -32768, 0),
                 o16(-25536, 25536, 25536, 0)};

      repeat (3) @(negedge clk);
      chk("reset busy", {busy0, busy1, busy2, busy3, busy4}, '0);
      chk("reset done", {done0, done1, done2, done3, done4}, '0);
      chk("reset out 2x2", {out0, out1, out2}, '0);
      chk("reset out3", out3, '0);
      chk("reset out4", out4, '0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         start_u0(tbl[i].m, 1'b0, tbl[i].e0, tbl[i].e1, tbl[i].e2);
         wait_u0();
      end

      start_u0(tbl[0].m, 1'b0, tbl[0].e0, tbl[0].e1, tbl[0].e2);
      n = 0;
      while (busy0 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("busy cycles", n, 3);
      start_u0(tbl[0].m, 1'b1, o32(38, 44, 86, 100), o16(38, 44, 86, 100),
               o16(38, 44, 86, 100));
      wait_u0();

      start_u0(tbl[0].m, 1'b0, tbl[0].e0, tbl[0].e1, tbl[0].e2);
      start0 = 1'b1;
      m0     = tbl[1].m;
      @(negedge clk);
      start0 = 1'b0;
      m0     = '1;
      wait_u0();

      start0 = 1'b1;
      m0     = tbl[1].m;
      acc0   = 1'b0;
      @(negedge clk);
      start0 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst busy", {busy0, busy1, busy2}, '0);
      chk("rst done", {done0, done1, done2}, '0);
      chk("rst out", {out0, out1, out2}, '0);
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (done0) n++;
      end
      chk("no done after rst", n, 0);
      start_u0(tbl[1].m, 1'b0, tbl[1].e0, tbl[1].e1, tbl[1].e2);
      wait_u0();

      prev3 = '0;
      for (int it = 0; it < 12; it++) begin
         for (int w = 0; w < 7; w++)
            m3[w*16 +: 16] = (it == 0) ? 16'h8000 :
                             (it == 1) ? 16'h7fff : 16'($urandom);
         a = (it > 2) ? 1'($urandom) : 1'b0;
         e = ref_mm(m3, prev3, 3, 1, 4, 32, 1'b1, a);
         start3 = 1'b1;
         acc3   = a;
         q3.push_back('{e, '0, '0, cyc + 1});
         @(negedge clk);
         start3 = 1'b0;
         prev3  = e;
         for (int i = 0; i < 20 && q3.size() != 0; i++) @(negedge clk);
         if (q3.size() != 0) begin
            chk("u3 done timeout", q3.size(), 0);
            q3.delete();
         end
      end

      prev4 = '0;
      for (int it = 0; it < 12; it++) begin
         for (int w = 0; w < 16; w++)
            m4[w*16 +: 16] = (it == 0) ? 16'h8000 :
                             (it == 1) ? 16'h7fff : 16'($urandom);
         a = (it > 2) ? 1'($urandom) : 1'b0;
         e = ref_mm(m4, prev4, 1, 8, 1, 32, 1'b1, a);
         start4 = 1'b1;
         acc4   = a;
         q4.push_back('{e, '0, '0, cyc + 1});
         @(negedge clk);
         start4 = 1'b0;
         prev4  = e;
         for (int i = 0; i < 30 && q4.size() != 0; i++) @(negedge clk);
         if (q4.size() != 0) begin
            chk("u4 done timeout", q4.size(), 0);
            q4.delete();
         end
      end

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/matrix_multiply_seq.md
# matrix_multiply_seq

Parametrised sequential signed matrix multiplier computing C = A·B (or C = C + A·B) for an ROWS×INNER by INNER×COLS operand pair. It keeps the flat packed-bus operand format of the existing matrix blocks. It adds a synchronous reset, a start/busy/done handshake, a registered-product pipeline, an accumulate mode and selectable saturating or wrapping output. It sits between the AXI register file and the Ising spin-update logic, which consumes the packed result.

## Interface
- ROWS, 2, rows of A and C
- INNER, 2, columns of A / rows of B (reduction length, ≥1)
- COLS, 2, columns of B and C
- DATA_W, 16, signed operand width
- OUT_W, 32, signed result element width
- SATURATE, 1, 1 = clamp results to OUT_W range; 0 = two's-complement wrap (keep low OUT_W bits)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when accepting (see Timing)
- acc_mode  in  1  sampled with start; 1 = accumulate onto current matrix_out
- matrix_in  in  DATA_W*(ROWS*INNER+INNER*COLS)  packed operands: A(r,k) at word r*INNER+k; B(k,c) at word ROWS*INNER+k*COLS+c
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid and updated
- matrix_out  out  OUT_W*ROWS*COLS  packed signed result, C(r,c) at word r*COLS+c

## Operation
- States: IDLE, MUL, DRAIN, DONE.
- IDLE: on start=1, do all of the following, then go to MUL:
  - latch matrix_in and acc_mode into internal registers;
  - load each accumulator with 0, or, if acc_mode=1, with the sign-extended current matrix_out word;
  - set k=0.
- MUL: each cycle, register all ROWS*COLS products A(r,k)·B(k,c) (full 2*DATA_W signed). Add the previous cycle's products (from k−1) into the accumulators. After k=INNER−1, go to DRAIN.
- DRAIN: add the final products. Go to DONE.
- DONE: write matrix_out from the accumulators (saturated or wrapped per SATURATE), pulse done, then return to IDLE.
- A start in the DONE cycle is accepted exactly as in IDLE, giving back-to-back operation.
- Accumulator width ACC_W = max(OUT_W, 2*DATA_W) + clog2(INNER) + 1. The internal sum never overflows.
- Saturation bounds: +2^(OUT_W−1)−1 and −2^(OUT_W−1).
- matrix_in changes after the start cycle have no effect on the running operation.
- matrix_out holds its value between done pulses.

## Timing
- Reset values: busy=0, done=0, matrix_out=0, state IDLE, k=0.
- rst overrides everything, including mid-operation. The result is discarded and there is no done pulse.
- Let E0 be the edge that samples an accepted start.
  - busy=1 from after E0 through after E0+INNER+1, i.e. during MUL and DRAIN.
  - busy=0 in the DONE cycle.
  - done=1 and the new matrix_out are visible after edge E0+INNER+2, for exactly one cycle of done.
- Latency: INNER+2 cycles from start to done.
- Throughput: one operation per INNER+2 cycles.
- start while busy=1 is ignored and not queued.
- INNER=1: MUL lasts one cycle, latency is 3.

## Test plan
- 2×2×2, DATA_W=16, OUT_W=32, acc_mode=0: A=[[1,2],[3,4]], B=[[5,6],[7,8]]. Required: matrix_out=[[19,22],[43,50]], done exactly 4 edges after start, busy high 3 cycles.
- Signed: A=[[−1,2],[3,−4]], B=[[5,−6],[−7,8]]. Required: [[−19,22],[43,−50]].
- Accumulate: repeat the first case with acc_mode=1 immediately after (start in the DONE cycle). Required: [[38,44],[86,100]], second done 4 edges after the second start.
- Saturation, OUT_W=16, SATURATE=1: all A=32767, B=[[32767,−32768],[32767,−32768]]. Required: every element with B=32767 equals 32767, every element with B=−32768 equals −32768. With SATURATE=0, elements equal the low 16 bits of 2·32767² (0x0002) and 2·(−32768·32767) (0x0000).
- Protocol: pulse start during busy with different operands. Required: ignored, result is from the first operands. Then rst mid-MUL: busy, done and matrix_out are 0 the next cycle, no done pulse follows, and a subsequent start completes normally.
- Parameter sweep ROWS=3, INNER=1, COLS=4 and ROWS=1, INNER=8, COLS=1, random operands against a reference model. Required: exact match, latency INNER+2.
